// File: rtl/fetch_unit_if.sv
// Bundle of fetch-unit handshakes: instruction memory read port, decode-side
// instruction stream, and the redirect path from execute.
interface fetch_unit_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_misaligned;

  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_data,
    output instr_valid, instr_data, instr_pc,
    input  instr_ready,
    input  redirect_valid, redirect_pc,
    output redirect_misaligned
  );

  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_data,
    input  instr_valid, instr_data, instr_pc,
    output instr_ready,
    output redirect_valid, redirect_pc,
    input  redirect_misaligned
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited in-order memory reads into a small
// instruction buffer, with redirect flushing and stale-response discarding.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t        state, state_nxt;
  logic [31:0]   fpc, fpc_nxt, rsp_pc, req_addr, redir_pc;
  logic          req_valid, stale_pend, mis;
  logic [CW-1:0] out_cnt, cnt, disc_cnt;
  logic [CW-1:0] out_nxt, cnt_nxt, disc_nxt;
  logic [CW:0]   credit_sum;
  logic [PW-1:0] head, tail;
  logic [31:0]   buf_data [DEPTH];
  logic [31:0]   buf_pc   [DEPTH];
  logic          accept, rsp, redir, pop, keep, push, stale_acc, hold, have;

  always_comb begin
    have       = (cnt != '0);
    accept     = req_valid && bus.mem_req_ready;
    hold       = req_valid && !bus.mem_req_ready;
    redir      = bus.redirect_valid && (state != IDLE);
    rsp        = bus.mem_rsp_valid && (out_cnt != '0);
    pop        = have && bus.instr_ready;
    keep       = rsp && (disc_cnt == '0) && !redir;
    // Full buffer with a response should be impossible; drop rather than overwrite.
    push       = keep && ((cnt != CW'(DEPTH)) || pop);
    stale_acc  = accept && stale_pend;
    redir_pc   = {bus.redirect_pc[31:2], 2'b00};
    out_nxt    = out_cnt + CW'(accept) - CW'(rsp);
    cnt_nxt    = redir ? '0 : cnt + CW'(push) - CW'(pop);
    disc_nxt   = redir ? out_nxt
                       : disc_cnt + CW'(stale_acc) - CW'(rsp && (disc_cnt != '0));
    // A held stale request must not advance fpc: it already points at the target.
    fpc_nxt    = redir ? redir_pc : ((accept && !stale_pend) ? fpc + 32'd4 : fpc);
    credit_sum = {1'b0, out_nxt} + {1'b0, cnt_nxt};

    state_nxt = state;
    case (state)
      IDLE:       state_nxt = RUN;
      RUN, FLUSH: begin
        if (redir)
          state_nxt = (out_nxt != '0) ? FLUSH : RUN;
        else if ((state == FLUSH) && (disc_nxt == '0))
          state_nxt = RUN;
      end
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      fpc        <= RESET_PC;
      req_valid  <= 1'b0;
      req_addr   <= RESET_PC;
      rsp_pc     <= RESET_PC;
      out_cnt    <= '0;
      cnt        <= '0;
      disc_cnt   <= '0;
      head       <= '0;
      tail       <= '0;
      stale_pend <= 1'b0;
      mis        <= 1'b0;
    end else begin
      state      <= state_nxt;
      fpc        <= fpc_nxt;
      out_cnt    <= out_nxt;
      cnt        <= cnt_nxt;
      disc_cnt   <= disc_nxt;
      mis        <= redir && (bus.redirect_pc[1:0] != 2'b00);
      stale_pend <= redir ? hold : (stale_pend && !accept);
      // A presented request is frozen until accepted, whatever else happens.
      if (!hold) begin
        req_valid <= (state_nxt == RUN) && (credit_sum < (CW+1)'(DEPTH));
        req_addr  <= fpc_nxt;
      end
      if (redir) begin
        head   <= '0;
        tail   <= '0;
        rsp_pc <= redir_pc;
      end else begin
        if (pop)  head   <= head + PW'(1);
        if (push) tail   <= tail + PW'(1);
        if (keep) rsp_pc <= rsp_pc + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[tail] <= bus.mem_rsp_data;
      buf_pc[tail]   <= rsp_pc;
    end
  end

  assign bus.mem_req_valid       = req_valid;
  assign bus.mem_req_addr        = req_addr;
  assign bus.instr_valid         = have;
  assign bus.instr_data          = have ? buf_data[head] : '0;
  assign bus.instr_pc            = have ? buf_pc[head] : '0;
  assign bus.redirect_misaligned = mis;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic, checked
// against a transaction-level model of fetch order, discards and delivery.
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 2;

  typedef struct {
    logic [31:0] addr;
    bit          stale;
    int          rdy;
  } req_t;

  logic clk, rst;
  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, since_rst = 0, n_pops_total = 0;
  int p_ready = 100, p_dec = 100, p_rsp = 100, lat_max = 0;
  bit rsp_en = 1, rnd_redir = 0, do_redir = 0;
  logic [31:0] redir_tgt = 0;

  req_t        mem_q[$];
  logic [31:0] exp_buf[$];
  logic [31:0] acc_log[$];
  logic [31:0] pop_log[$];
  logic [31:0] m_fpc = RST_PC;
  bit          pend_stale = 0, prev_hold = 0, exp_mis = 0;
  logic [31:0] prev_addr = 0;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  function automatic logic [31:0] log_at(input int kind, input int idx);
    if (kind == 0) return (acc_log.size() > idx) ? acc_log[idx] : 32'hDEAD_BEEF;
    return (pop_log.size() > idx) ? pop_log[idx] : 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.mem_req_ready  = 1'b0;
    bus.mem_rsp_valid  = 1'b0;
    bus.mem_rsp_data   = '0;
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    #1;
    chk("rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("rst_req_addr",  bus.mem_req_addr, RST_PC);
    chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instr_data", bus.instr_data, 32'd0);
    chk("rst_instr_pc",  bus.instr_pc, 32'd0);
    chk("rst_misaligned", 32'(bus.redirect_misaligned), 32'd0);
    mem_q.delete();
    exp_buf.delete();
    m_fpc = RST_PC;
    pend_stale = 0;
    prev_hold = 0;
    exp_mis = 0;
    since_rst = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic step();
    bit acc, pp, rs, rd;
    req_t e;
    logic [31:0] tgt;
    @(negedge clk);
    chk("instr_valid", 32'(bus.instr_valid), 32'(exp_buf.size() != 0));
    if (exp_buf.size() != 0) begin
      chk("instr_pc", bus.instr_pc, exp_buf[0]);
      chk("instr_data", bus.instr_data, memfn(exp_buf[0]));
    end
    chk("misaligned", 32'(bus.redirect_misaligned), 32'(exp_mis));
    if (prev_hold) begin
      chk("hold_valid", 32'(bus.mem_req_valid), 32'd1);
      chk("hold_addr", bus.mem_req_addr, prev_addr);
    end else if (bus.mem_req_valid) begin
      chk("credit", 32'((mem_q.size() + exp_buf.size()) < DEPTH), 32'd1);
    end
    if (bus.mem_req_valid) chk("addr_align", 32'(bus.mem_req_addr[1:0]), 32'd0);

    bus.mem_req_ready = ($urandom_range(99) < p_ready);
    bus.instr_ready   = ($urandom_range(99) < p_dec);
    rs = rsp_en && (mem_q.size() != 0) && (mem_q[0].rdy <= cyc) && ($urandom_range(99) < p_rsp);
    bus.mem_rsp_valid = rs;
    bus.mem_rsp_data  = rs ? memfn(mem_q[0].addr) : $urandom();
    rd = do_redir || (rnd_redir && since_rst > 0 && $urandom_range(99) < 4);
    tgt = do_redir ? redir_tgt : $urandom();
    if (!do_redir && $urandom_range(1) == 1) tgt = tgt & 32'h0000_0FFF;
    bus.redirect_valid = rd;
    bus.redirect_pc    = tgt;
    do_redir = 0;

    acc = bus.mem_req_valid && bus.mem_req_ready;
    pp  = (exp_buf.size() != 0) && bus.instr_ready;
    if (pp) begin
      pop_log.push_back(exp_buf.pop_front());
      n_pops_total++;
    end
    if (rs) begin
      e = mem_q.pop_front();
      if (!e.stale && !rd) exp_buf.push_back(e.addr);
    end
    if (acc) begin
      acc_log.push_back(bus.mem_req_addr);
      e.rdy = cyc + 1 + int'($urandom_range(lat_max));
      if (pend_stale) begin
        e.addr = bus.mem_req_addr;
        e.stale = 1;
        pend_stale = 0;
      end else begin
        chk("req_addr", bus.mem_req_addr, m_fpc);
        e.addr = m_fpc;
        e.stale = 0;
        m_fpc = m_fpc + 32'd4;
      end
      mem_q.push_back(e);
    end
    if (rd) begin
      foreach (mem_q[i]) mem_q[i].stale = 1;
      exp_buf.delete();
      m_fpc = {tgt[31:2], 2'b00};
      if (bus.mem_req_valid && !bus.mem_req_ready) pend_stale = 1;
    end
    exp_mis   = rd && (tgt[1:0] != 2'b00);
    prev_hold = bus.mem_req_valid && !bus.mem_req_ready;
    prev_addr = bus.mem_req_addr;
    cyc++;
    since_rst++;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    do_reset();

    // Free-running fetch: sequential addresses and delivery order.
    acc_log.delete(); pop_log.delete();
    repeat (12) step();
    chk("seq_req0", log_at(0, 0), 32'h0);
    chk("seq_req1", log_at(0, 1), 32'h4);
    chk("seq_req2", log_at(0, 2), 32'h8);
    chk("seq_pc0", log_at(1, 0), 32'h0);
    chk("seq_pc1", log_at(1, 1), 32'h4);
    chk("seq_pc2", log_at(1, 2), 32'h8);

    // Decode stall: credit stops fetch at DEPTH, resumes at 0x8.
    do_reset();
    acc_log.delete(); pop_log.delete();
    p_dec = 0;
    repeat (10) step();
    chk("stall_accepts", 32'(acc_log.size()), 32'(DEPTH));
    chk("stall_req_valid", 32'(bus.mem_req_valid), 32'd0);
    p_dec = 100;
    acc_log.delete();
    repeat (4) step();
    chk("stall_resume", log_at(0, 0), 32'h8);

    // Redirect with two requests outstanding.
    do_reset();
    rsp_en = 0;
    repeat (6) step();
    chk("outstanding2", 32'(mem_q.size()), 32'd2);
    do_redir = 1; redir_tgt = 32'h100;
    step();
    acc_log.delete(); pop_log.delete();
    rsp_en = 1;
    repeat (10) step();
    chk("flush_next_req", log_at(0, 0), 32'h100);
    chk("flush_first_pc", log_at(1, 0), 32'h100);

    // Redirect while a request is held by mem_req_ready low.
    do_reset();
    acc_log.delete(); pop_log.delete();
    p_ready = 0;
    step();
    do_redir = 1; redir_tgt = 32'h100;
    step();
    step();
    p_ready = 100;
    repeat (8) step();
    chk("held_req", log_at(0, 0), RST_PC);
    chk("held_next_req", log_at(0, 1), 32'h100);
    chk("held_first_pc", log_at(1, 0), 32'h100);

    // Misaligned redirect target.
    do_redir = 1; redir_tgt = 32'h102;
    step();
    @(posedge clk); #1;
    chk("mis_pulse", 32'(bus.redirect_misaligned), 32'd1);
    acc_log.delete();
    repeat (6) step();
    chk("mis_next_req", log_at(0, 0), 32'h100);

    // Address wrap at the top of the space.
    do_redir = 1; redir_tgt = 32'hFFFF_FFF8;
    step();
    acc_log.delete();
    repeat (8) step();
    chk("wrap_req0", log_at(0, 0), 32'hFFFF_FFF8);
    chk("wrap_req1", log_at(0, 1), 32'hFFFF_FFFC);
    chk("wrap_req2", log_at(0, 2), 32'h0000_0000);

    // Reset pulse mid-stream, then refetch from the reset address.
    repeat (3) step();
    do_reset();
    acc_log.delete(); pop_log.delete();
    repeat (6) step();
    chk("rerst_req", log_at(0, 0), RST_PC);
    chk("rerst_pc", log_at(1, 0), RST_PC);

    // Randomized traffic with random redirects and one reset.
    p_ready = 70; p_dec = 60; p_rsp = 70; lat_max = 3; rnd_redir = 1;
    n_pops_total = 0;
    repeat (1500) step();
    do_reset();
    repeat (1500) step();
    chk("random_progress", 32'(n_pops_total > 100), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
